// File: rtl/tl45_wb_pkg.sv
// Shared types and bus widths for the TL45 memory-side Wishbone arbiter.
package tl45_wb_pkg;

  localparam int WB_AW = 30;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/tl45_wb_watchdog.sv
// Outstanding-request tracker plus bus watchdog; fire pulses when an owned
// bus cycle has waited TIMEOUT cycles for a response that never came.
module tl45_wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_active,
  input  logic i_clear,
  input  logic i_stb_accept,
  input  logic i_resp,
  output logic o_fire
);

  localparam logic [7:0] FIRE_AT = 8'(TIMEOUT - 1);

  logic [3:0] outs_q, outs_d;
  logic [7:0] timer_q, timer_d;

  // The response wins over a timeout landing in the same cycle.
  assign o_fire = i_active && (outs_q != 4'd0) && !i_resp && (timer_q == FIRE_AT);

  always_comb begin
    outs_d  = outs_q;
    timer_d = timer_q;
    if (!i_active || i_clear) begin
      outs_d  = 4'd0;
      timer_d = 8'd0;
    end else begin
      if (i_stb_accept && !i_resp) begin
        if (outs_q != 4'd15) outs_d = outs_q + 4'd1;
      end else if (!i_stb_accept && i_resp) begin
        if (outs_q != 4'd0) outs_d = outs_q - 4'd1;
      end
      if (i_resp) timer_d = 8'd0;
      else if (outs_q != 4'd0) timer_d = timer_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      outs_q  <= 4'd0;
      timer_q <= 8'd0;
    end else begin
      outs_q  <= outs_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/tl45_wb_arbiter.sv
// Two-master pipelined Wishbone arbiter: prefetch (m0) and load/store (m1)
// share one slave bus; whole cycles are granted and cyc acts as the lock.
module tl45_wb_arbiter
  import tl45_wb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_m0_cyc,
  input  logic             i_m0_stb,
  input  logic             i_m0_we,
  input  logic [WB_AW-1:0] i_m0_addr,
  input  logic [WB_DW-1:0] i_m0_data,
  input  logic [WB_SW-1:0] i_m0_sel,
  output logic             o_m0_ack,
  output logic             o_m0_stall,
  output logic             o_m0_err,
  output logic [WB_DW-1:0] o_m0_data,
  input  logic             i_m1_cyc,
  input  logic             i_m1_stb,
  input  logic             i_m1_we,
  input  logic [WB_AW-1:0] i_m1_addr,
  input  logic [WB_DW-1:0] i_m1_data,
  input  logic [WB_SW-1:0] i_m1_sel,
  output logic             o_m1_ack,
  output logic             o_m1_stall,
  output logic             o_m1_err,
  output logic [WB_DW-1:0] o_m1_data,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic [WB_AW-1:0] o_wb_addr,
  output logic [WB_DW-1:0] o_wb_data,
  output logic [WB_SW-1:0] o_wb_sel,
  input  logic             i_wb_ack,
  input  logic             i_wb_stall,
  input  logic             i_wb_err,
  input  logic [WB_DW-1:0] i_wb_data,
  output logic [1:0]       o_grant
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       wd_fire;

  assign o_m0_data = i_wb_data;
  assign o_m1_data = i_wb_data;
  assign o_grant   = {state_q == ARB_OWN1, state_q == ARB_OWN0};

  // Release always passes through IDLE, so an owner change costs one idle cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_m0_cyc && i_m1_cyc)
          state_d = ((ROUND_ROBIN != 0) && last_grant_q) ? ARB_OWN0 : ARB_OWN1;
        else if (i_m0_cyc)
          state_d = ARB_OWN0;
        else if (i_m1_cyc)
          state_d = ARB_OWN1;
      end
      ARB_OWN0: begin
        if (!i_m0_cyc || wd_fire) begin
          state_d      = ARB_IDLE;
          last_grant_d = 1'b0;
        end
      end
      ARB_OWN1: begin
        if (!i_m1_cyc || wd_fire) begin
          state_d      = ARB_IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // A watchdog fire kills the slave-side cycle and reports err to the owner.
  always_comb begin
    o_wb_cyc   = 1'b0;
    o_wb_stb   = 1'b0;
    o_wb_we    = 1'b0;
    o_wb_addr  = '0;
    o_wb_data  = '0;
    o_wb_sel   = '0;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m0_stall = 1'b1;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    o_m1_stall = 1'b1;
    case (state_q)
      ARB_OWN0: begin
        o_wb_cyc   = i_m0_cyc & ~wd_fire;
        o_wb_stb   = i_m0_stb & ~wd_fire;
        o_wb_we    = i_m0_we;
        o_wb_addr  = i_m0_addr;
        o_wb_data  = i_m0_data;
        o_wb_sel   = i_m0_sel;
        o_m0_ack   = i_wb_ack;
        o_m0_err   = i_wb_err | wd_fire;
        o_m0_stall = i_wb_stall | wd_fire;
      end
      ARB_OWN1: begin
        o_wb_cyc   = i_m1_cyc & ~wd_fire;
        o_wb_stb   = i_m1_stb & ~wd_fire;
        o_wb_we    = i_m1_we;
        o_wb_addr  = i_m1_addr;
        o_wb_data  = i_m1_data;
        o_wb_sel   = i_m1_sel;
        o_m1_ack   = i_wb_ack;
        o_m1_err   = i_wb_err | wd_fire;
        o_m1_stall = i_wb_stall | wd_fire;
      end
      default: ;
    endcase
  end

  tl45_wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_active    (state_q != ARB_IDLE),
    .i_clear     (state_d != state_q),
    .i_stb_accept(o_wb_stb & ~i_wb_stall),
    .i_resp      (i_wb_ack | i_wb_err),
    .o_fire      (wd_fire)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_tl45_wb_arbiter.sv
// Bench for tl45_wb_arbiter: two instances (round-robin and fixed-priority)
// share stimulus and are compared every cycle against a behavioural model.
module tb_tl45_wb_arbiter;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        m_cyc [2] = '{1'b0, 1'b0};
  logic        m_stb [2] = '{1'b0, 1'b0};
  logic        m_we  [2] = '{1'b0, 1'b0};
  logic [29:0] m_addr[2] = '{30'd0, 30'd0};
  logic [31:0] m_data[2] = '{32'd0, 32'd0};
  logic [3:0]  m_sel [2] = '{4'd0, 4'd0};
  logic        wb_ack = 1'b0, wb_stall = 1'b0, wb_err = 1'b0;
  logic [31:0] wb_rdata = 32'd0;

  logic [1:0]  grant[2];
  logic        wcyc[2], wstb[2], wwe[2];
  logic [29:0] waddr[2];
  logic [31:0] wdata[2];
  logic [3:0]  wsel[2];
  logic        ack0[2], stall0[2], err0[2], ack1[2], stall1[2], err1[2];
  logic [31:0] d0[2], d1[2];

  int checks = 0;
  int failures = 0;
  int n_ack0 = 0;
  int n_ack1 = 0;

  // Model state per instance: owner (-1 idle), last owner, outstanding, silent cycles.
  int own [2] = '{-1, -1};
  int last[2] = '{0, 0};
  int outs[2] = '{0, 0};
  int tmr [2] = '{0, 0};

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    tl45_wb_arbiter #(
      .ROUND_ROBIN(k == 0 ? 1 : 0),
      .TIMEOUT    (TIMEOUT)
    ) u_dut (
      .i_clk     (clk),
      .i_reset   (i_reset),
      .i_m0_cyc  (m_cyc[0]),
      .i_m0_stb  (m_stb[0]),
      .i_m0_we   (m_we[0]),
      .i_m0_addr (m_addr[0]),
      .i_m0_data (m_data[0]),
      .i_m0_sel  (m_sel[0]),
      .o_m0_ack  (ack0[k]),
      .o_m0_stall(stall0[k]),
      .o_m0_err  (err0[k]),
      .o_m0_data (d0[k]),
      .i_m1_cyc  (m_cyc[1]),
      .i_m1_stb  (m_stb[1]),
      .i_m1_we   (m_we[1]),
      .i_m1_addr (m_addr[1]),
      .i_m1_data (m_data[1]),
      .i_m1_sel  (m_sel[1]),
      .o_m1_ack  (ack1[k]),
      .o_m1_stall(stall1[k]),
      .o_m1_err  (err1[k]),
      .o_m1_data (d1[k]),
      .o_wb_cyc  (wcyc[k]),
      .o_wb_stb  (wstb[k]),
      .o_wb_we   (wwe[k]),
      .o_wb_addr (waddr[k]),
      .o_wb_data (wdata[k]),
      .o_wb_sel  (wsel[k]),
      .i_wb_ack  (wb_ack),
      .i_wb_stall(wb_stall),
      .i_wb_err  (wb_err),
      .i_wb_data (wb_rdata),
      .o_grant   (grant[k])
    );
  end

  task automatic check(string nm, int k, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, k, $time, act, exp);
    end
  endtask

  function automatic logic fire_now(int k);
    return (own[k] >= 0) && (outs[k] > 0) && !(wb_ack || wb_err) && (tmr[k] == TIMEOUT - 1);
  endfunction

  // Model advance: arbitration rules, per-grant outstanding count, silence timer.
  always @(posedge clk or posedge i_reset) begin
    logic f, resp, acc;
    int o;
    for (int k = 0; k < 2; k++) begin
      if (i_reset) begin
        own[k] = -1; last[k] = 0; outs[k] = 0; tmr[k] = 0;
      end else if (own[k] < 0) begin
        if (m_cyc[0] && m_cyc[1]) own[k] = (k == 0) ? 1 - last[k] : 1;
        else if (m_cyc[0]) own[k] = 0;
        else if (m_cyc[1]) own[k] = 1;
      end else begin
        o = own[k];
        f = fire_now(k);
        if (f || !m_cyc[o]) begin
          last[k] = o; own[k] = -1; outs[k] = 0; tmr[k] = 0;
        end else begin
          resp = wb_ack || wb_err;
          acc  = m_stb[o] && !wb_stall;
          if (resp) tmr[k] = 0;
          else if (outs[k] > 0) tmr[k] = tmr[k] + 1;
          if (acc && !resp && outs[k] < 15) outs[k] = outs[k] + 1;
          else if (resp && !acc && outs[k] > 0) outs[k] = outs[k] - 1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs of both instances.
  always @(negedge clk) begin
    logic [1:0]  eg;
    logic [68:0] ewb;
    logic [34:0] e0, e1, er;
    logic f;
    int o;
    for (int k = 0; k < 2; k++) begin
      eg  = 2'b00;
      ewb = '0;
      e0  = {1'b0, 1'b1, 1'b0, wb_rdata};
      e1  = {1'b0, 1'b1, 1'b0, wb_rdata};
      if (own[k] >= 0) begin
        o   = own[k];
        f   = fire_now(k);
        eg  = (o == 0) ? 2'b01 : 2'b10;
        ewb = {m_cyc[o] && !f, m_stb[o] && !f, m_we[o], m_addr[o], m_data[o], m_sel[o]};
        er  = {wb_ack, wb_stall || f, wb_err || f, wb_rdata};
        if (o == 0) e0 = er; else e1 = er;
      end
      check("grant", k, grant[k], eg);
      check("wb_bus", k, {wcyc[k], wstb[k], wwe[k], waddr[k], wdata[k], wsel[k]}, ewb);
      check("m0_resp", k, {ack0[k], stall0[k], err0[k], d0[k]}, e0);
      check("m1_resp", k, {ack1[k], stall1[k], err1[k], d1[k]}, e1);
    end
    if (ack0[0]) n_ack0++;
    if (ack1[0]) n_ack1++;
  end

  task automatic next();
    @(posedge clk);
    #1;
    wb_rdata = $urandom;
  endtask

  task automatic set_m(int m, logic c, logic s);
    m_cyc[m]  = c;
    m_stb[m]  = s;
    m_we[m]   = 1'($urandom);
    m_addr[m] = 30'($urandom);
    m_data[m] = $urandom;
    m_sel[m]  = 4'($urandom);
  endtask

  task automatic idle_inputs();
    set_m(0, 1'b0, 1'b0);
    set_m(1, 1'b0, 1'b0);
    wb_ack = 1'b0; wb_stall = 1'b0; wb_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_reset = 1'b1;
    next();
    next();
    i_reset = 1'b0;
  endtask

  initial begin
    int found;
    idle_inputs();
    next();
    @(negedge clk);
    check("rst_grant", 0, grant[0], 2'b00);
    check("rst_stall", 0, {stall0[0], stall1[0], ack0[0], err1[0]}, 4'b1100);
    check("rst_wbcyc", 0, {wcyc[0], waddr[0]}, 31'd0);
    do_reset();

    // Cache-line fill by m0: 16 strobes, ack one cycle behind each.
    next(); set_m(0, 1'b1, 1'b1); n_ack0 = 0; n_ack1 = 0;
    @(negedge clk);
    check("fill_wait_grant", 0, grant[0], 2'b00);
    check("fill_wait_stall", 0, stall0[0], 1'b1);
    for (int t = 1; t <= 16; t++) begin
      next(); set_m(0, 1'b1, 1'b1); wb_ack = (t >= 2);
      if (t == 1) begin
        @(negedge clk);
        check("fill_grant", 0, grant[0], 2'b01);
      end
    end
    next(); set_m(0, 1'b1, 1'b0); wb_ack = 1'b1;
    next(); set_m(0, 1'b0, 1'b0); wb_ack = 1'b0;
    @(negedge clk);
    check("fill_drop_cyc", 0, {wcyc[0], grant[0]}, 3'b001);
    next();
    @(negedge clk);
    check("fill_idle", 0, grant[0], 2'b00);
    next();
    check("fill_m0_acks", 0, n_ack0, 16);
    check("fill_m1_acks", 0, n_ack1, 0);

    // Simultaneous requests.
    do_reset();
    next(); set_m(0, 1'b1, 1'b0); set_m(1, 1'b1, 1'b0);
    next();
    @(negedge clk);
    check("tie1_grant", 0, grant[0], 2'b10);
    check("tie1_grant", 1, grant[1], 2'b10);
    next(); set_m(1, 1'b0, 1'b0);
    next(); set_m(1, 1'b1, 1'b0);
    next();
    @(negedge clk);
    check("tie2_grant", 0, grant[0], 2'b01);
    check("tie2_m1_stall", 0, stall1[0], 1'b1);
    check("tie2_grant", 1, grant[1], 2'b10);
    next(); set_m(0, 1'b0, 1'b0); set_m(1, 1'b0, 1'b0);
    next();
    next(); set_m(0, 1'b1, 1'b0); set_m(1, 1'b1, 1'b0);
    next();
    @(negedge clk);
    check("tie3_grant", 0, grant[0], 2'b10);
    check("tie3_grant", 1, grant[1], 2'b10);
    next(); idle_inputs();

    // Watchdog: one strobe from m1, slave silent.
    do_reset();
    next(); set_m(1, 1'b1, 1'b1);
    next();
    next(); set_m(1, 1'b1, 1'b0);
    found = -1;
    for (int c = 2; c < 400; c++) begin
      @(negedge clk);
      if (err1[0]) begin
        found = c;
        break;
      end
      next();
    end
    check("wd_latency", 0, found - 1, TIMEOUT);
    check("wd_cyc_forced", 0, wcyc[0], 1'b0);
    next(); set_m(1, 1'b0, 1'b0);
    @(negedge clk);
    check("wd_idle", 0, {grant[0], err1[0]}, 3'b000);

    // Abort with outstanding requests, then a stray ack.
    do_reset();
    next(); set_m(0, 1'b1, 1'b1);
    for (int t = 1; t <= 3; t++) begin
      next(); set_m(0, 1'b1, 1'b1);
    end
    next(); set_m(0, 1'b0, 1'b0);
    next(); wb_ack = 1'b1;
    @(negedge clk);
    check("abort_idle", 0, grant[0], 2'b00);
    check("abort_stray_ack", 0, {ack0[0], ack1[0]}, 2'b00);
    next(); wb_ack = 1'b0;

    // Reset in the middle of an m0 burst while m1 waits.
    do_reset();
    next(); set_m(0, 1'b1, 1'b1);
    next(); set_m(0, 1'b1, 1'b1);
    next(); set_m(0, 1'b1, 1'b1);
    next(); set_m(0, 1'b1, 1'b0); set_m(1, 1'b1, 1'b1);
    #2 i_reset = 1'b1;
    #1;
    check("rst_async_grant", 0, grant[0], 2'b00);
    check("rst_async_bus", 0, {wcyc[0], wstb[0], waddr[0], stall0[0], stall1[0]}, 35'b11);
    next(); i_reset = 1'b0; set_m(0, 1'b0, 1'b0);
    next();
    @(negedge clk);
    check("rst_m1_grant", 0, grant[0], 2'b10);
    check("rst_m1_grant", 1, grant[1], 2'b10);
    next(); idle_inputs();

    // Randomised traffic.
    for (int n = 0; n < 4000; n++) begin
      next();
      for (int m = 0; m < 2; m++) begin
        if (m_cyc[m]) set_m(m, ($urandom_range(0, 11) != 0), 1'b0);
        else set_m(m, ($urandom_range(0, 3) == 0), 1'b0);
        m_stb[m] = m_cyc[m] && 1'($urandom);
      end
      wb_ack   = ($urandom_range(0, 2) == 0);
      wb_err   = ($urandom_range(0, 24) == 0);
      wb_stall = ($urandom_range(0, 3) == 0);
      i_reset  = ($urandom_range(0, 499) == 0);
    end
    next(); i_reset = 1'b0; idle_inputs();
    next();
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl45_wb_arbiter.md
# tl45_wb_arbiter

Two-master Wishbone (pipelined) arbiter that shares the single memory-side bus between the instruction prefetch/cache-fill unit (master 0) and the load/store unit (master 1). It grants whole bus cycles, with `cyc` held as the lock, and steers `ack`/`err`/`stall` to the owner only. It also runs a bus-watchdog that terminates hung cycles with an error. It sits between the core's two bus masters and the system interconnect.

## Interface
- `ROUND_ROBIN`, 1: 1 = alternate on simultaneous requests; 0 = master 1 (data) always wins ties.
- `TIMEOUT`, 255: cycles without an ack while requests are outstanding before the watchdog fires; 8-bit counter.
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_m0_cyc`, `i_m0_stb`, `i_m0_we`  in  1 each  master 0 request.
- `i_m0_addr`  in  30  master 0 word address.
- `i_m0_data`  in  32  master 0 write data.
- `i_m0_sel`  in  4  master 0 byte select.
- `o_m0_ack`, `o_m0_stall`, `o_m0_err`  out  1 each  master 0 response.
- `o_m0_data`  out  32  read data; broadcast from the slave.
- `i_m1_*` / `o_m1_*`: identical set for master 1.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1 each  slave-side request.
- `o_wb_addr`  out  30  slave-side word address.
- `o_wb_data`  out  32  slave-side write data.
- `o_wb_sel`  out  4  slave-side byte select.
- `i_wb_ack`, `i_wb_stall`, `i_wb_err`  in  1 each  slave response.
- `i_wb_data`  in  32  slave read data.
- `o_grant`  out  2  one-hot owner, for debug; 00 = idle.

## Operation
- States are IDLE, OWN0 and OWN1, held in a registered state variable.
- IDLE:
  - Only `m0_cyc` asserted -> OWN0.
  - Only `m1_cyc` asserted -> OWN1.
  - Both asserted -> if `ROUND_ROBIN`, grant the master that was not granted last (`last_grant` register, reset 0, so master 1 wins the first tie); otherwise OWN1.
- OWNx:
  - The owner's `cyc`, `stb`, `we`, `addr`, `data` and `sel` pass combinationally to `o_wb_*`.
  - `o_mx_stall` = `i_wb_stall`.
  - `o_mx_ack` = `i_wb_ack`.
  - `o_mx_err` = `i_wb_err`.
- Non-owner and idle masters:
  - `stall` = 1, `ack` = 0, `err` = 0.
  - They see no `ack`/`err`, ever.
- In IDLE, `o_wb_cyc` = `o_wb_stb` = 0, `o_wb_we` = 0, and the other `o_wb_*` outputs are 0.
- OWNx -> IDLE on the first cycle the owner samples `cyc` = 0. `last_grant` is updated to x on that transition.
- There is no re-grant in the same cycle: IDLE always lasts at least 1 cycle between owners.
- Outstanding counter (4 bits, per grant):
  - +1 on `o_wb_stb & !i_wb_stall`.
  - -1 on `i_wb_ack | i_wb_err`.
  - Both in the same cycle -> unchanged.
  - Saturates at 15; does not wrap.
  - Cleared on entry to IDLE. An owner dropping `cyc` with count > 0 aborts the cycle; late acks after release are discarded.
- Watchdog (8 bits):
  - Counts while in OWNx with outstanding > 0 and no `ack`/`err` that cycle.
  - Cleared on any `ack`/`err` or on state change.
  - On reaching `TIMEOUT`: assert `o_mx_err` = 1 to the owner for one cycle, force `o_wb_cyc` = 0 that cycle and after, and go to IDLE. This is the same error path the prefetch unit already handles: it returns to IDLE and retries.

## Timing
- Grant latency: `cyc` rises in cycle N with the bus idle -> `o_grant` and `o_wb_cyc`/`o_wb_stb` are visible in N+1. The requester sees `stall` = 1 in N and holds its request.
- Pass-through has zero added latency once granted. `ack` and `data` reach the owner in the same cycle as `i_wb_ack`.
- Release: owner `cyc` = 0 in cycle M -> `o_wb_cyc` = 0 in M (combinational) -> state is IDLE at M+1 -> the next owner is granted at M+2.
- Simultaneous `i_wb_ack` and owner `cyc` drop: the ack is still routed to the owner.
- Simultaneous `i_wb_ack` and watchdog fire: the ack wins and the watchdog clears.
- On `i_reset` (asynchronous, any state):
  - State goes to IDLE.
  - `last_grant` = 0.
  - Both counters = 0.
  - `o_grant` = 00.
  - All `o_wb_*` outputs = 0.
  - All `o_mx_ack`/`o_mx_err` = 0.
  - All `o_mx_stall` = 1.
- An in-flight cycle is abandoned by reset with no ack or err delivered.

## Structure
- Shared package `tl45_wb_pkg`:
  - State enum `{ARB_IDLE, ARB_OWN0, ARB_OWN1}`.
  - Width constants: `WB_AW` = 30, `WB_DW` = 32, `WB_SW` = 4.
- One sub-module, `tl45_wb_watchdog`: the timeout counter plus the outstanding counter, exposing a `fire` output. It is reusable by a future data-side bridge.
- The mux and the FSM stay in the top module.

## Test plan
- Single master: m0 issues 16 strobes (a cache-line fill) with 0-stall acks -> grant 01 from cycle 1; 16 acks reach only m0; `o_m1_ack` stays 0; back to IDLE 1 cycle after `cyc` drops.
- Tie with `ROUND_ROBIN` = 1: both raise `cyc` after reset -> m1 granted first. Both retry immediately after release -> m0 granted next, and m1 sees `stall` = 1 throughout m0's cycle.
- Tie with `ROUND_ROBIN` = 0: three back-to-back ties -> m1 granted all three times.
- Watchdog: m1 issues 1 strobe and the slave never acks -> exactly 255 cycles later `o_m1_err` pulses for 1 cycle, `o_wb_cyc` falls, and the state returns to IDLE.
- Abort: m0 drops `cyc` with 3 outstanding -> IDLE next cycle; a subsequent stray `i_wb_ack` produces no ack on either master.
- Reset mid-burst: `i_reset` asserted during OWN0 with 2 outstanding -> outputs go to their reset values without waiting for a clock edge; after release, m1's pending request is granted within 1 cycle.
